// File: rtl/div_ratio_checker.sv
// div_ratio_checker: measures high/low run lengths of a divided clock and checks them against an expected pattern
//   clk, reset          : system clock, synchronous active-high reset
//   enable              : low forces IDLE and clears status
//   sig_in              : divided signal under test (clk-synchronous)
//   exp_high, exp_low   : expected run lengths, captured while IDLE
//   meas_high, meas_low : run lengths of the last completed period
//   period_valid        : one-cycle pulse per completed period
//   locked, fault       : lock status and sticky post-lock fault
//   err_count           : saturating count of bad or stalled periods
module div_ratio_checker #(
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 2,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sig_in,
    input  logic [CNT_W-1:0] exp_high,
    input  logic [CNT_W-1:0] exp_low,
    output logic [CNT_W-1:0] meas_high,
    output logic [CNT_W-1:0] meas_low,
    output logic             period_valid,
    output logic             locked,
    output logic             fault,
    output logic [ERR_W-1:0] err_count
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [GW-1:0] LOCK_V = GW'(LOCK_CNT);

    typedef enum logic [2:0] {IDLE, SYNC, MEASURE, LOCKED, FAULT} state_t;

    state_t           state_q, state_d;
    logic             prev_q;
    logic [CNT_W-1:0] run_q, run_d, hold_q, hold_d;
    logic [CNT_W-1:0] exp_high_q, exp_high_d, exp_low_q, exp_low_d;
    logic [CNT_W-1:0] meas_high_q, meas_high_d, meas_low_q, meas_low_d;
    logic [GW-1:0]    good_q, good_d, good_inc;
    logic [ERR_W-1:0] err_q, err_d, err_sat;
    logic             pv_q, pv_d, locked_q, locked_d, fault_q, fault_d;
    logic             rise, fall, run_sat, stall, match;

    assign rise     = sig_in & ~prev_q;
    assign fall     = ~sig_in & prev_q;
    assign run_sat  = &run_q;
    // a stall is a level held past what the run counter can represent
    assign stall    = run_sat & ~rise & ~fall;
    // zero expectations can never match, even against a never-written hold_q
    assign match    = (hold_q == exp_high_q) && (run_q == exp_low_q) && |exp_high_q && |exp_low_q;
    assign err_sat  = (&err_q) ? err_q : err_q + ERR_W'(1);
    assign good_inc = good_q + GW'(1);

    always_comb begin
        state_d     = state_q;
        exp_high_d  = (state_q == IDLE) ? exp_high : exp_high_q;
        exp_low_d   = (state_q == IDLE) ? exp_low : exp_low_q;
        run_d       = (rise | fall) ? CNT_W'(1) : (run_sat ? run_q : run_q + CNT_W'(1));
        hold_d      = fall ? run_q : hold_q;
        meas_high_d = meas_high_q;
        meas_low_d  = meas_low_q;
        good_d      = good_q;
        err_d       = err_q;
        pv_d        = 1'b0;
        locked_d    = locked_q;
        fault_d     = fault_q;
        if (!enable) begin
            state_d  = IDLE;
            good_d   = '0;
            err_d    = '0;
            locked_d = 1'b0;
            fault_d  = 1'b0;
        end else if (state_q == IDLE) begin
            state_d = SYNC;
        end else if (state_q == SYNC) begin
            if (rise) begin
                state_d = MEASURE;
                good_d  = '0;
            end
        end else if (rise) begin
            meas_high_d = hold_q;
            meas_low_d  = run_q;
            pv_d        = 1'b1;
            if (state_q == MEASURE) begin
                good_d  = match ? good_inc : '0;
                err_d   = match ? err_q : err_sat;
                if (match && good_inc == LOCK_V) begin
                    state_d  = LOCKED;
                    locked_d = 1'b1;
                end
            end else if (!match) begin
                state_d  = FAULT;
                err_d    = err_sat;
                fault_d  = 1'b1;
                locked_d = 1'b0;
            end
        end else if (stall && state_q != FAULT) begin
            // leaving MEASURE/LOCKED on the first stalled cycle makes the error count once
            err_d    = err_sat;
            good_d   = '0;
            state_d  = (state_q == MEASURE) ? SYNC : FAULT;
            fault_d  = (state_q == LOCKED) | fault_q;
            locked_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            prev_q      <= 1'b0;
            run_q       <= '0;
            hold_q      <= '0;
            exp_high_q  <= '0;
            exp_low_q   <= '0;
            meas_high_q <= '0;
            meas_low_q  <= '0;
            good_q      <= '0;
            err_q       <= '0;
            pv_q        <= 1'b0;
            locked_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= sig_in;
            run_q       <= run_d;
            hold_q      <= hold_d;
            exp_high_q  <= exp_high_d;
            exp_low_q   <= exp_low_d;
            meas_high_q <= meas_high_d;
            meas_low_q  <= meas_low_d;
            good_q      <= good_d;
            err_q       <= err_d;
            pv_q        <= pv_d;
            locked_q    <= locked_d;
            fault_q     <= fault_d;
        end
    end

    assign meas_high    = meas_high_q;
    assign meas_low     = meas_low_q;
    assign period_valid = pv_q;
    assign locked       = locked_q;
    assign fault        = fault_q;
    assign err_count    = err_q;
endmodule

// File: tb/tb_div_ratio_checker.sv
// tb_div_ratio_checker: scoreboard bench for div_ratio_checker using directed divider patterns
module tb_div_ratio_checker;
    logic       clk = 1'b0;
    logic       reset, enable, sig_in;
    logic [7:0] exp_high, exp_low, meas_high, meas_low, err_count;
    logic       period_valid, locked, fault;

    typedef struct {
        logic [7:0] h;
        logic [7:0] l;
        logic       lk;
        logic       ft;
        logic [7:0] err;
        int         gap;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   last_pv = 0;

    div_ratio_checker #(.CNT_W(8), .LOCK_CNT(2), .ERR_W(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .sig_in(sig_in),
        .exp_high(exp_high), .exp_low(exp_low),
        .meas_high(meas_high), .meas_low(meas_low),
        .period_valid(period_valid), .locked(locked), .fault(fault),
        .err_count(err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (period_valid) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_period: got meas %0d/%0d expected none", meas_high, meas_low);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("meas_high", 32'(meas_high), 32'(e.h));
                chk("meas_low", 32'(meas_low), 32'(e.l));
                chk("locked", 32'(locked), 32'(e.lk));
                chk("fault", 32'(fault), 32'(e.ft));
                chk("err_count", 32'(err_count), 32'(e.err));
                if (e.gap != 0) chk("pv_spacing", 32'(cyc - last_pv), 32'(e.gap));
            end
            last_pv = cyc;
        end
    end

    task automatic rst_dut();
        reset = 1'b1;
        enable = 1'b0;
        sig_in = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic start(input logic [7:0] eh, input logic [7:0] el);
        exp_high = eh;
        exp_low = el;
        enable = 1'b1;
        sig_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic per(input int h, input int l);
        sig_in = 1'b1;
        repeat (h) @(posedge clk);
        #1;
        sig_in = 1'b0;
        repeat (l) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] h, input logic [7:0] l, input logic lk,
                        input logic ft, input logic [7:0] err, input int gap);
        exp_t e;
        e.h = h; e.l = l; e.lk = lk; e.ft = ft; e.err = err; e.gap = gap;
        q.push_back(e);
    endtask

    task automatic closing();
        sig_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        exp_high = 8'd0;
        exp_low = 8'd0;
        rst_dut();
        rst_dut();
        chk("rst_meas_high", 32'(meas_high), 32'd0);
        chk("rst_meas_low", 32'(meas_low), 32'd0);
        chk("rst_pv", 32'(period_valid), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);

        // Div2
        start(8'd1, 8'd1);
        per(1, 1); push(1, 1, 0, 0, 0, 0);
        per(1, 1); push(1, 1, 1, 0, 0, 2);
        per(1, 1); push(1, 1, 1, 0, 0, 2);
        per(1, 1); push(1, 1, 1, 0, 0, 2);
        closing();

        // Div9 then a swapped-duty period after lock
        rst_dut();
        start(8'd4, 8'd5);
        per(4, 5); push(4, 5, 0, 0, 0, 0);
        per(4, 5); push(4, 5, 1, 0, 0, 9);
        per(4, 5); push(4, 5, 1, 0, 0, 9);
        per(5, 4); push(5, 4, 0, 1, 1, 9);
        per(4, 5); push(4, 5, 0, 1, 1, 9);
        per(4, 5); push(4, 5, 0, 1, 1, 9);
        closing();

        // Div80
        rst_dut();
        start(8'd40, 8'd40);
        per(40, 40); push(40, 40, 0, 0, 0, 0);
        per(40, 40); push(40, 40, 1, 0, 0, 80);
        per(40, 40); push(40, 40, 1, 0, 0, 80);
        closing();

        // Stall after lock
        rst_dut();
        start(8'd4, 8'd5);
        per(4, 5); push(4, 5, 0, 0, 0, 0);
        per(4, 5); push(4, 5, 1, 0, 0, 9);
        sig_in = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        chk("stall_fault", 32'(fault), 32'd1);
        chk("stall_locked", 32'(locked), 32'd0);
        chk("stall_err", 32'(err_count), 32'd1);
        repeat (50) @(posedge clk);
        #1;
        chk("stall_err_held", 32'(err_count), 32'd1);
        chk("stall_queue", 32'(q.size()), 32'd0);

        // Pre-lock mismatch, then reset while locked
        rst_dut();
        start(8'd4, 8'd5);
        per(3, 5); push(3, 5, 0, 0, 1, 0);
        per(4, 5); push(4, 5, 0, 0, 1, 9);
        per(4, 5); push(4, 5, 1, 0, 1, 9);
        closing();
        chk("prereset_locked", 32'(locked), 32'd1);
        rst_dut();
        chk("midrst_meas_high", 32'(meas_high), 32'd0);
        chk("midrst_meas_low", 32'(meas_low), 32'd0);
        chk("midrst_locked", 32'(locked), 32'd0);
        chk("midrst_err", 32'(err_count), 32'd0);
        chk("midrst_pv", 32'(period_valid), 32'd0);

        // enable dropped for one cycle, then relock
        start(8'd4, 8'd5);
        per(3, 5); push(3, 5, 0, 0, 1, 0);
        per(4, 5); push(4, 5, 0, 0, 1, 9);
        per(4, 5); push(4, 5, 1, 0, 1, 9);
        closing();
        enable = 1'b0;
        @(posedge clk); #1;
        chk("en_locked", 32'(locked), 32'd0);
        chk("en_fault", 32'(fault), 32'd0);
        chk("en_err", 32'(err_count), 32'd0);
        chk("en_meas_high", 32'(meas_high), 32'd4);
        chk("en_meas_low", 32'(meas_low), 32'd5);
        start(8'd4, 8'd5);
        per(4, 5); push(4, 5, 0, 0, 0, 0);
        per(4, 5); push(4, 5, 1, 0, 0, 9);
        closing();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
